// File: rtl/lane_gearbox_pkg.sv
// Shared TMDS token definitions and small elaboration helpers for the lane gearbox.
package lane_gearbox_pkg;

  localparam logic [9:0] TMDS_CTL00     = 10'b1101010100;
  localparam logic [9:0] TMDS_CTL01     = 10'b0010101011;
  localparam logic [9:0] TMDS_CTL10     = 10'b0101010100;
  localparam logic [9:0] TMDS_CTL11     = 10'b1010101011;
  localparam logic [9:0] TMDS_CLK_PATTN = 10'b0000011111;

  // Control-period token for a {c1, c0} control pair.
  function automatic logic [9:0] tmds_ctl_token(input logic [1:0] ctl);
    case (ctl)
      2'b00:   return TMDS_CTL00;
      2'b01:   return TMDS_CTL01;
      2'b10:   return TMDS_CTL10;
      default: return TMDS_CTL11;
    endcase
  endfunction

  // Three data lanes in control period 00, clock lane on top.
  localparam logic [39:0] TMDS_IDLE_DEFAULT = {TMDS_CLK_PATTN, tmds_ctl_token(2'b00),
                                               tmds_ctl_token(2'b00), tmds_ctl_token(2'b00)};

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gearbox_lane.sv
// One serial lane: idle substitution, bit-slip window, polarity invert and the
// output shift register that feeds the DDR output stage LSB first.
module gearbox_lane
  import lane_gearbox_pkg::*;
#(
  parameter int               SYM_W    = 10,
  parameter int               OUT_W    = 2,
  parameter logic [SYM_W-1:0] IDLE_SYM = '0
) (
  input  logic             clk_shift,
  input  logic             reset,
  input  logic             load,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             invert,
  input  logic             bitslip,
  output logic [OUT_W-1:0] dout
);

  localparam int               ROT_W   = clog2_min1(SYM_W);
  localparam logic [ROT_W-1:0] ROT_MAX = ROT_W'(SYM_W - 1);
  localparam logic [ROT_W:0]   SYM_W_L = (ROT_W + 1)'(SYM_W);

  logic [SYM_W-1:0]   prev;
  logic [SYM_W-1:0]   shift;
  logic [SYM_W-1:0]   new_sym;
  logic [SYM_W-1:0]   word;
  logic [ROT_W-1:0]   rot;
  logic [ROT_W:0]     shamt;
  logic [2*SYM_W-1:0] window;

  // rot bits of the previous symbol's tail are pushed in front of the new one.
  always_comb begin
    new_sym = sym_valid ? sym : IDLE_SYM;
    window  = {new_sym, prev};
    shamt   = SYM_W_L - {1'b0, rot};
    word    = SYM_W'(window >> shamt);
  end

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      prev  <= '0;
      shift <= '0;
      rot   <= '0;
    end else begin
      if (load) begin
        prev  <= new_sym;
        shift <= word ^ {SYM_W{invert}};
      end else begin
        shift <= shift >> OUT_W;
      end
      // A slip coincident with a load only affects the following load.
      if (bitslip) begin
        rot <= (rot == ROT_MAX) ? '0 : rot + ROT_W'(1);
      end
    end
  end

  assign dout = shift[OUT_W-1:0];

endmodule

// File: rtl/lane_gearbox.sv
// Multi-lane symbol serialiser on the fast shift clock: phase counter, load
// handshake, idle insertion bookkeeping and a saturating underrun counter.
module lane_gearbox
  import lane_gearbox_pkg::*;
#(
  parameter int                     LANES     = 4,
  parameter int                     SYM_W     = 10,
  parameter int                     OUT_W     = 2,
  parameter logic [LANES*SYM_W-1:0] IDLE_SYMS = TMDS_IDLE_DEFAULT,
  parameter int                     CNT_W     = 16
) (
  input  logic                   clk_shift,
  input  logic                   reset,
  input  logic [LANES*SYM_W-1:0] sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [LANES-1:0]       invert,
  input  logic [LANES-1:0]       bitslip,
  output logic [LANES*OUT_W-1:0] dout,
  output logic                   underrun,
  output logic [CNT_W-1:0]       underrun_cnt
);

  localparam int              PH      = SYM_W / OUT_W;
  localparam int              PH_W    = clog2_min1(PH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH - 1);

  if (SYM_W % OUT_W != 0) begin : g_bad_ratio
    $error("lane_gearbox: SYM_W must be a multiple of OUT_W");
  end

  logic [PH_W-1:0] phase;
  logic            load;
  logic            armed;
  logic            slot_underrun;

  // Handshake: sym_ready marks the one load slot per symbol period; a transfer
  // happens only when sym_valid is also high at that edge, otherwise idle is loaded.
  assign load          = (phase == PH_LAST);
  assign sym_ready     = load;
  assign slot_underrun = load && !sym_valid && armed;

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      phase        <= '0;
      armed        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      phase    <= load ? '0 : phase + PH_W'(1);
      underrun <= slot_underrun;
      if (load && sym_valid) begin
        armed <= 1'b1;
      end
      if (slot_underrun && (underrun_cnt != {CNT_W{1'b1}})) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gearbox_lane #(
      .SYM_W   (SYM_W),
      .OUT_W   (OUT_W),
      .IDLE_SYM(IDLE_SYMS[SYM_W*i +: SYM_W])
    ) u_lane (
      .clk_shift(clk_shift),
      .reset    (reset),
      .load     (load),
      .sym_valid(sym_valid),
      .sym      (sym_in[SYM_W*i +: SYM_W]),
      .invert   (invert[i]),
      .bitslip  (bitslip[i]),
      .dout     (dout[OUT_W*i +: OUT_W])
    );
  end

endmodule

// File: tb/tb_lane_gearbox.sv
// Bench for lane_gearbox: default instance, a CNT_W=2 instance on the same
// stimulus, and an OUT_W=1 instance left idle, all against a queue-based model.
module tb_lane_gearbox;

  localparam int SYM_W = 10;
  localparam int PH    = 5;
  localparam int PHB   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [39:0] sym_in;
  logic        sym_valid;
  logic [3:0]  invert;
  logic [3:0]  bitslip;
  logic        sym_ready;
  logic [7:0]  dout;
  logic        underrun;
  logic [15:0] underrun_cnt;

  logic        sat_ready;
  logic [7:0]  sat_dout;
  logic        sat_underrun;
  logic [1:0]  sat_cnt;

  logic [39:0] b_sym_in;
  logic        b_valid;
  logic [3:0]  b_invert;
  logic [3:0]  b_bitslip;
  logic        b_ready;
  logic [3:0]  b_dout;
  logic        b_underrun;
  logic [15:0] b_cnt;

  lane_gearbox u_dut (
    .clk_shift(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .invert(invert), .bitslip(bitslip), .dout(dout),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  lane_gearbox #(.CNT_W(2)) u_sat (
    .clk_shift(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sat_ready), .invert(invert), .bitslip(bitslip), .dout(sat_dout),
    .underrun(sat_underrun), .underrun_cnt(sat_cnt)
  );

  lane_gearbox #(.OUT_W(1)) u_bit (
    .clk_shift(clk), .reset(reset), .sym_in(b_sym_in), .sym_valid(b_valid),
    .sym_ready(b_ready), .invert(b_invert), .bitslip(b_bitslip), .dout(b_dout),
    .underrun(b_underrun), .underrun_cnt(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0] idle_sym [4] = '{10'b1101010100, 10'b1101010100, 10'b1101010100, 10'b0000011111};
  logic [1:0] lane3_exp [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
  logic [1:0] lane0_exp [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_dout;
  logic [9:0]  m_prev [4];
  int          m_rot  [4];
  logic [9:0]  m_w    [4];
  logic [9:0]  m_new;
  logic [19:0] m_win;
  logic [7:0]  m_v;
  logic [3:0]  b_exp;
  bit          started = 0;
  bit          m_armed;
  bit          m_under;
  int          m_cnt;
  int          m_sat;
  int          cyc;

  // cyc is the index of the current cycle since the last reset edge.
  always @(posedge clk) begin
    if (reset) begin
      started  = 1;
      cyc      = 0;
      exp_q.delete();
      exp_dout = '0;
      for (int l = 0; l < 4; l++) begin
        m_prev[l] = '0;
        m_rot[l]  = 0;
      end
      m_armed = 0;
      m_under = 0;
      m_cnt   = 0;
      m_sat   = 0;
    end else if (started) begin
      if (cyc % PH == PH - 1) begin
        for (int l = 0; l < 4; l++) begin
          m_new  = sym_valid ? sym_in[10*l +: 10] : idle_sym[l];
          m_win  = {m_new, m_prev[l]} >> (SYM_W - m_rot[l]);
          m_w[l] = m_win[9:0] ^ (invert[l] ? 10'h3FF : 10'h000);
          m_prev[l] = m_new;
        end
        for (int k = 0; k < PH; k++) begin
          for (int l = 0; l < 4; l++) m_v[2*l +: 2] = m_w[l][2*k +: 2];
          exp_q.push_back(m_v);
        end
        m_under = !sym_valid && m_armed;
        if (m_under) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_sat < 3) m_sat++;
        end
        if (sym_valid) m_armed = 1;
      end else begin
        m_under = 0;
      end
      for (int l = 0; l < 4; l++) if (bitslip[l]) m_rot[l] = (m_rot[l] + 1) % SYM_W;
      exp_dout = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("dout", dout, exp_dout);
      chk("sat_dout", sat_dout, exp_dout);
      chk("ready", sym_ready, cyc % PH == PH - 1);
      chk("sat_ready", sat_ready, cyc % PH == PH - 1);
      chk("underrun", underrun, m_under);
      chk("sat_underrun", sat_underrun, m_under);
      chk("underrun_cnt", underrun_cnt, m_cnt);
      chk("sat_cnt", sat_cnt, m_sat);
      for (int l = 0; l < 4; l++)
        b_exp[l] = (cyc < PHB) ? 1'b0 : idle_sym[l][(cyc - PHB) % PHB];
      chk("bit_dout", b_dout, b_exp);
      chk("bit_ready", b_ready, cyc % PHB == PHB - 1);
      chk("bit_underrun", b_underrun, 1'b0);
      chk("bit_cnt", b_cnt, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_slot();
    while (cyc % PH != PH - 1) tick();
  endtask

  task automatic send(input bit v, input logic [9:0] s);
    to_slot();
    sym_valid = v;
    sym_in    = {4{s}};
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym_in = '0; invert = '0; bitslip = '0;
    b_sym_in = '0; b_valid = 1'b0; b_invert = '0; b_bitslip = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle tokens before arming
    while (cyc < 5) tick();
    for (int k = 0; k < 5; k++) begin
      chk("idle_lane3", dout[7:6], lane3_exp[k]);
      chk("idle_lane0", dout[1:0], lane0_exp[k]);
      tick();
    end
    while (cyc < 20) tick();
    chk("idle_no_count", underrun_cnt, 0);

    // Continuous valid, alternating all-ones / all-zeros
    for (int n = 0; n < 6; n++) begin
      send(1'b1, (n % 2) ? 10'h000 : 10'h3FF);
      chk("alt_first", dout, (n % 2) ? 8'h00 : 8'hFF);
    end

    // One missed slot after arming
    send(1'b0, 10'h000);
    chk("underrun_pulse", underrun, 1'b1);
    chk("underrun_one", underrun_cnt, 1);
    chk("idle_inserted", dout, 8'hC0);
    tick();
    chk("underrun_clear", underrun, 1'b0);
    send(1'b1, 10'h155);

    // Four more misses: 16-bit counter reaches 5, 2-bit counter saturates
    repeat (4) send(1'b0, 10'h000);
    chk("underrun_five", underrun_cnt, 5);
    chk("underrun_sat", sat_cnt, 2'd3);
    send(1'b1, 10'h2AA);

    // Polarity invert on lane 0, toggled off mid-symbol
    invert = 4'b0001;
    send(1'b1, 10'h001);
    chk("inv_chunk0", dout[1:0], 2'b10);
    invert = 4'b0000;
    tick(); tick();
    chk("inv_hold", dout[1:0], 2'b11);
    send(1'b1, 10'h001);
    chk("inv_off", dout[1:0], 2'b01);

    // Bit-slip on lane 1 coincident with a load
    to_slot();
    bitslip = 4'b0010; sym_valid = 1'b1; sym_in = {4{10'h001}};
    tick();
    bitslip = 4'b0000;
    chk("slip_same", dout[3:2], 2'b01);
    send(1'b1, 10'h001);
    chk("slip_next", dout[3:2], 2'b10);
    for (int p = 0; p < 9; p++) begin
      tick();
      bitslip = 4'b0010;
      tick();
      bitslip = 4'b0000;
    end
    send(1'b1, 10'h001);
    chk("slip_wrap", dout[3:2], 2'b01);
    send(1'b1, 10'h001);
    chk("slip_wrap2", dout[3:2], 2'b01);

    // Reset mid-symbol discards the partial symbol
    send(1'b1, 10'h3FF);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_cnt", underrun_cnt, 0);
    chk("rst_ready", sym_ready, 1'b0);
    reset = 1'b0; sym_valid = 1'b0;
    while (cyc < 35) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
